// File: rtl/enemy_pkg.sv
// Shared types and constants for the per-enemy contact monitor.
// Pure definitions: no logic, no latency.
package enemy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIT    = 2'd1,
        INVULN = 2'd2
    } contact_state_t;

    localparam logic [10:0] SCREEN_W    = 11'd640;
    localparam int          SPRITE_HALF = 10;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] size_y;
        logic       alive;
    } player_snap_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       alive;
    } enemy_snap_t;

endpackage

// File: rtl/contact_fsm.sv
// One player's IDLE/HIT/INVULN damage FSM with invulnerability frame counter.
// hit/bounce pulse in the cycle cls_vld is high; no backpressure. Blink needs CONTACT_FLASH_EN.
module contact_fsm
    import enemy_pkg::*;
#(
    parameter int INVULN_FRAMES = 60
) (
    input  logic Clk,
    input  logic Reset,
    input  logic cls_vld,
    input  logic stomp,
    input  logic contact,
    input  logic alive,
    output logic hit,
    output logic bounce,
    output logic invuln,
    output logic blink
);

    // At least 3 bits so the blink tap always exists.
    localparam int CNT_W = (INVULN_FRAMES < 8) ? 3 : $clog2(INVULN_FRAMES + 1);

    contact_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        bounce  = 1'b0;
        if (!alive) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cls_vld && contact) begin
                        hit     = 1'b1;
                        state_d = HIT;
                    end else if (cls_vld && stomp) begin
                        bounce = 1'b1;
                    end
                end
                HIT: begin
                    cnt_d   = CNT_W'(INVULN_FRAMES);
                    state_d = (INVULN_FRAMES == 0) ? IDLE : INVULN;
                end
                INVULN: begin
                    // Contact is ignored while invulnerable; stomps still bounce.
                    if (cls_vld) begin
                        bounce = stomp;
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign invuln = (state_q != IDLE);

`ifdef CONTACT_FLASH_EN
    assign blink = invuln && cnt_q[2];
`else
    assign blink = 1'b0;
`endif

endmodule

// File: rtl/enemy_contact_monitor.sv
// Frame-synchronised stomp/contact classifier for one enemy, driving Mario and Luigi damage FSMs.
// frame_clk rise -> hit/bounce pulse in 4 Clk; no backpressure. Blink option: CONTACT_FLASH_EN.
module enemy_contact_monitor
    import enemy_pkg::*;
#(
    parameter int INVULN_FRAMES = 60,
    parameter int ENEMY_HALF    = SPRITE_HALF,
    parameter int STOMP_BAND    = 11
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] enemy_X_Pos,
    input  logic [9:0] enemy_Y_Pos,
    input  logic       enemy_health,
    input  logic [9:0] mario_x,
    input  logic [9:0] luigi_x,
    input  logic [9:0] mario_y,
    input  logic [9:0] luigi_y,
    input  logic [9:0] mario_Size_Y,
    input  logic [9:0] luigi_Size_Y,
    input  logic [1:0] mario_health,
    input  logic [1:0] luigi_health,
    output logic       mario_hit,
    output logic       luigi_hit,
    output logic       mario_bounce,
    output logic       luigi_bounce,
    output logic       mario_invuln,
    output logic       luigi_invuln,
    output logic       mario_blink,
    output logic       luigi_blink
);

    localparam logic signed [10:0] HALF_S  = 11'(ENEMY_HALF);
    localparam logic signed [10:0] WIDTH_S = 11'(2 * ENEMY_HALF);
    localparam logic signed [10:0] BAND_S  = 11'(STOMP_BAND);

    logic [2:0]   sync_q;
    logic         tick_q;
    logic         cls_vld;
    enemy_snap_t  snap_e;
    player_snap_t snap_m, snap_l;
    logic         enemy_present;
    logic [1:0]   cls_m, cls_l;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= '0;
            tick_q  <= 1'b0;
            cls_vld <= 1'b0;
            snap_e  <= '0;
            snap_m  <= '0;
            snap_l  <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], frame_clk};
            tick_q  <= sync_q[1] & ~sync_q[2];
            cls_vld <= tick_q;
            if (tick_q) begin
                snap_e <= '{x: enemy_X_Pos, y: enemy_Y_Pos, alive: enemy_health};
                snap_m <= '{x: mario_x, y: mario_y, size_y: mario_Size_Y, alive: (mario_health != 2'd0)};
                snap_l <= '{x: luigi_x, y: luigi_y, size_y: luigi_Size_Y, alive: (luigi_health != 2'd0)};
            end
        end
    end

    // Returns {stomp, contact}; zero-extended signed maths so small enemy X/Y never wraps.
    function automatic logic [1:0] classify(input player_snap_t p, input enemy_snap_t e,
                                            input logic eligible);
        logic signed [10:0] dx, bot, top, ey;
        logic               ovl, stp;
        dx  = $signed({1'b0, p.x}) - $signed({1'b0, e.x});
        bot = $signed({1'b0, p.y}) + $signed({1'b0, p.size_y});
        top = $signed({1'b0, p.y}) - $signed({1'b0, p.size_y});
        ey  = $signed({1'b0, e.y});
        ovl = (dx < WIDTH_S) && (dx > -WIDTH_S) && (bot > ey - HALF_S) && (top < ey + HALF_S);
        stp = ovl && (bot > ey - BAND_S) && (bot < ey);
        return {eligible && stp, eligible && ovl && !stp};
    endfunction

    always_comb begin
        enemy_present = snap_e.alive && ({1'b0, snap_e.x} < SCREEN_W);
        cls_m = classify(snap_m, snap_e, snap_m.alive && enemy_present);
        cls_l = classify(snap_l, snap_e, snap_l.alive && enemy_present);
    end

    contact_fsm #(.INVULN_FRAMES(INVULN_FRAMES)) u_mario_fsm (
        .Clk     (Clk),
        .Reset   (Reset),
        .cls_vld (cls_vld),
        .stomp   (cls_m[1]),
        .contact (cls_m[0]),
        .alive   (mario_health != 2'd0),
        .hit     (mario_hit),
        .bounce  (mario_bounce),
        .invuln  (mario_invuln),
        .blink   (mario_blink)
    );

    contact_fsm #(.INVULN_FRAMES(INVULN_FRAMES)) u_luigi_fsm (
        .Clk     (Clk),
        .Reset   (Reset),
        .cls_vld (cls_vld),
        .stomp   (cls_l[1]),
        .contact (cls_l[0]),
        .alive   (luigi_health != 2'd0),
        .hit     (luigi_hit),
        .bounce  (luigi_bounce),
        .invuln  (luigi_invuln),
        .blink   (luigi_blink)
    );

endmodule

// File: tb/tb_enemy_contact_monitor.sv
// Directed bench: expected pulses are queued per frame tick and popped by an independent monitor.
module tb_enemy_contact_monitor;

`ifdef CONTACT_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
    logic [9:0] enemy_X_Pos, enemy_Y_Pos;
    logic       enemy_health;
    logic [9:0] mario_x, luigi_x, mario_y, luigi_y, mario_Size_Y, luigi_Size_Y;
    logic [1:0] mario_health, luigi_health;
    logic       mario_hit, luigi_hit, mario_bounce, luigi_bounce;
    logic       mario_invuln, luigi_invuln, mario_blink, luigi_blink;

    enemy_contact_monitor dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .enemy_X_Pos(enemy_X_Pos), .enemy_Y_Pos(enemy_Y_Pos), .enemy_health(enemy_health),
        .mario_x(mario_x), .luigi_x(luigi_x), .mario_y(mario_y), .luigi_y(luigi_y),
        .mario_Size_Y(mario_Size_Y), .luigi_Size_Y(luigi_Size_Y),
        .mario_health(mario_health), .luigi_health(luigi_health),
        .mario_hit(mario_hit), .luigi_hit(luigi_hit),
        .mario_bounce(mario_bounce), .luigi_bounce(luigi_bounce),
        .mario_invuln(mario_invuln), .luigi_invuln(luigi_invuln),
        .mario_blink(mario_blink), .luigi_blink(luigi_blink)
    );

    always #5 Clk = ~Clk;

    int cycle = 0;
    always @(posedge Clk) cycle <= cycle + 1;

    // Pulse vector order: {mario_hit, mario_bounce, luigi_hit, luigi_bounce}
    typedef struct {
        logic [3:0] p;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] mon_p;
    int         n_chk  = 0;
    int         n_fail = 0;

    always @(negedge Clk) begin
        mon_p = {mario_hit, mario_bounce, luigi_hit, luigi_bounce};
        if (!Reset && mon_p != 4'b0000) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required no pulse", mon_p, cycle);
            end else begin
                mon_e = sb.pop_front();
                if (mon_p !== mon_e.p || cycle != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             mon_p, cycle, mon_e.p, mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Raise frame_clk, queue the expected pulses 4 Clk later, then confirm they were all seen.
    task automatic frame_tick(input string name, input logic [3:0] p);
        exp_t e;
        @(negedge Clk);
        frame_clk = 1'b1;
        if (p != 4'b0000) begin
            e.p   = p;
            e.cyc = cycle + 4;
            sb.push_back(e);
        end
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        check({name, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (n) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic set_enemy(input int x, input int y, input logic h);
        enemy_X_Pos = 10'(x); enemy_Y_Pos = 10'(y); enemy_health = h;
    endtask

    task automatic set_mario(input int x, input int y, input int s, input int h);
        mario_x = 10'(x); mario_y = 10'(y); mario_Size_Y = 10'(s); mario_health = 2'(h);
    endtask

    task automatic set_luigi(input int x, input int y, input int s, input int h);
        luigi_x = 10'(x); luigi_y = 10'(y); luigi_Size_Y = 10'(s); luigi_health = 2'(h);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] exp_cnt;

    initial begin
        set_enemy(300, 200, 1'b1);
        set_mario(100, 100, 10, 2);
        set_luigi(500, 100, 10, 2);

        // Reset state
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("reset_pulses", {mario_hit, mario_bounce, luigi_hit, luigi_bounce}, 0);
        check("reset_invuln", {mario_invuln, luigi_invuln}, 0);
        check("reset_blink", {mario_blink, luigi_blink}, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset_invuln", {mario_invuln, luigi_invuln}, 0);

        // Side contact, then 60-frame invulnerability window with contact held
        set_mario(315, 200, 10, 2);
        frame_tick("side_hit", 4'b1000);
        check("side_invuln", mario_invuln, 1);
        check("side_blink", mario_blink, FLASH ? 1 : 0);
        check("side_luigi_invuln", luigi_invuln, 0);
        for (int k = 1; k < 60; k++) begin
            frame_tick("inv_hold", 4'b0000);
            exp_cnt = 8'(60 - k);
            check("inv_hold_invuln", mario_invuln, 1);
            check("inv_hold_blink", mario_blink, FLASH ? {31'd0, exp_cnt[2]} : 0);
        end
        frame_tick("inv_expire", 4'b0000);
        check("expire_invuln", mario_invuln, 0);
        check("expire_blink", mario_blink, 0);
        frame_tick("rehit", 4'b1000);
        check("rehit_invuln", mario_invuln, 1);

        // Reset mid-INVULN clears at once; next contact re-hits
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset_invuln", mario_invuln, 0);
        check("midreset_blink", mario_blink, 0);
        Reset = 1'b0;
        frame_tick("after_reset_hit", 4'b1000);
        check("after_reset_invuln", mario_invuln, 1);
        do_reset(2);

        // Stomp: bounce only, remains IDLE
        set_mario(300, 180, 15, 2);
        frame_tick("stomp", 4'b0100);
        check("stomp_invuln", mario_invuln, 0);
        frame_tick("stomp_again", 4'b0100);
        check("stomp_again_invuln", mario_invuln, 0);

        // Absent enemy with overlapping coordinates
        set_mario(315, 200, 10, 2);
        set_enemy(300, 200, 1'b0);
        frame_tick("enemy_dead", 4'b0000);
        check("enemy_dead_invuln", mario_invuln, 0);
        set_enemy(800, 200, 1'b1);
        set_mario(805, 200, 10, 2);
        frame_tick("enemy_offscreen", 4'b0000);
        check("offscreen_invuln", mario_invuln, 0);

        // Small enemy X must not wrap into a match
        set_enemy(5, 200, 1'b1);
        set_mario(630, 200, 10, 2);
        frame_tick("wrap_guard", 4'b0000);
        check("wrap_invuln", mario_invuln, 0);
        set_mario(20, 200, 10, 2);
        frame_tick("small_x_hit", 4'b1000);
        check("small_x_invuln", mario_invuln, 1);
        do_reset(2);

        // Both players hit together; stomp during INVULN still bounces
        set_enemy(300, 200, 1'b1);
        set_mario(315, 200, 10, 2);
        set_luigi(285, 200, 10, 1);
        frame_tick("both_hit", 4'b1010);
        check("both_invuln", {mario_invuln, luigi_invuln}, 2'b11);
        set_mario(300, 180, 15, 2);
        frame_tick("inv_stomp", 4'b0100);
        check("inv_stomp_invuln", {mario_invuln, luigi_invuln}, 2'b11);

        // Player death forces IDLE on the next cycle
        @(negedge Clk);
        mario_health = 2'd0;
        @(negedge Clk);
        check("dead_mario_invuln", mario_invuln, 0);
        check("dead_luigi_invuln", luigi_invuln, 1);
        frame_tick("dead_no_pulse", 4'b0000);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
